// File: rtl/shiftreg_multimode.sv
// Multi-mode LED pattern shift register: rotate-left, rotate-right, ping-pong and Johnson fill.
// Optional: define SHIFTREG_WRAP_CNT_EN to add the 16-bit o_wrap_cnt event counter.
module shiftreg_multimode #(
    parameter int NB_LEDS = 4,
    parameter int NB_DIV  = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [1:0]         i_mode,
    input  logic [NB_DIV-1:0]  i_div,
    input  logic               i_load,
    input  logic [NB_LEDS-1:0] i_pattern,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_step,
`ifdef SHIFTREG_WRAP_CNT_EN
    output logic               o_wrap,
    output logic [15:0]        o_wrap_cnt
`else
    output logic               o_wrap
`endif
);

    localparam logic [NB_LEDS-1:0] HOME = {{(NB_LEDS-1){1'b0}}, 1'b1};

    logic [NB_DIV-1:0]  div_cnt;
    logic               dir_left;
    logic [NB_LEDS-1:0] nxt_pat;
    logic               nxt_dir;
    logic               fire;

    function automatic logic [NB_LEDS-1:0] rot_left(input logic [NB_LEDS-1:0] p);
        return {p[NB_LEDS-2:0], p[NB_LEDS-1]};
    endfunction

    function automatic logic [NB_LEDS-1:0] rot_right(input logic [NB_LEDS-1:0] p);
        return {p[0], p[NB_LEDS-1:1]};
    endfunction

    function automatic logic [NB_LEDS-1:0] johnson(input logic [NB_LEDS-1:0] p);
        return {p[NB_LEDS-2:0], ~p[NB_LEDS-1]};
    endfunction

    assign fire = i_valid && (div_cnt == i_div);

    always_comb begin
        nxt_pat = o_led;
        nxt_dir = dir_left;
        case (i_mode)
            2'b00: nxt_pat = rot_left(o_led);
            2'b01: nxt_pat = rot_right(o_led);
            2'b10: begin
                // Bounce turns around on the step that finds the lit end, not one step later.
                if (dir_left && o_led[NB_LEDS-1]) begin
                    nxt_dir = 1'b0;
                    nxt_pat = rot_right(o_led);
                end else if (!dir_left && o_led[0]) begin
                    nxt_dir = 1'b1;
                    nxt_pat = rot_left(o_led);
                end else begin
                    nxt_pat = dir_left ? rot_left(o_led) : rot_right(o_led);
                end
            end
            default: nxt_pat = johnson(o_led);
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_led    <= HOME;
            dir_left <= 1'b1;
            div_cnt  <= '0;
            o_step   <= 1'b0;
            o_wrap   <= 1'b0;
        end else if (i_load) begin
            o_led    <= i_pattern;
            dir_left <= 1'b1;
            div_cnt  <= '0;
            o_step   <= 1'b0;
            o_wrap   <= 1'b0;
        end else begin
            o_step <= 1'b0;
            o_wrap <= 1'b0;
            if (fire) begin
                div_cnt  <= '0;
                o_led    <= nxt_pat;
                dir_left <= nxt_dir;
                o_step   <= 1'b1;
                o_wrap   <= (nxt_pat == HOME);
            end else if (i_valid) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef SHIFTREG_WRAP_CNT_EN
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_wrap_cnt <= 16'd0;
        end else if (i_load) begin
            o_wrap_cnt <= 16'd0;
        end else if (fire && (nxt_pat == HOME)) begin
            o_wrap_cnt <= o_wrap_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shiftreg_multimode.sv
// Directed bench for shiftreg_multimode (4 LEDs); covers o_wrap_cnt when SHIFTREG_WRAP_CNT_EN is defined.
module tb_shiftreg_multimode;

    localparam int NB = 4;
    localparam int ND = 8;

    logic          clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [1:0]    i_mode = 2'b00;
    logic [ND-1:0] i_div = '0;
    logic          i_load = 1'b0;
    logic [NB-1:0] i_pattern = '0;
    logic [NB-1:0] o_led;
    logic          o_step;
    logic          o_wrap;
`ifdef SHIFTREG_WRAP_CNT_EN
    logic [15:0]   o_wrap_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shiftreg_multimode #(.NB_LEDS(NB), .NB_DIV(ND)) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_mode    (i_mode),
        .i_div     (i_div),
        .i_load    (i_load),
        .i_pattern (i_pattern),
        .o_led     (o_led),
        .o_step    (o_step),
`ifdef SHIFTREG_WRAP_CNT_EN
        .o_wrap    (o_wrap),
        .o_wrap_cnt(o_wrap_cnt)
`else
        .o_wrap    (o_wrap)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [NB-1:0] led, input logic st, input logic wr);
        check({tag, "_led"},  32'(o_led),  32'(led));
        check({tag, "_step"}, 32'(o_step), 32'(st));
        check({tag, "_wrap"}, 32'(o_wrap), 32'(wr));
    endtask

    // One clock with the given i_valid; returns 1 ns after the edge.
    task automatic cyc(input logic v);
        i_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_load  = 1'b0;
        #3;
        @(posedge clock);
        #1;
        i_reset = 1'b0;
    endtask

    logic [NB-1:0] rl_tab [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NB-1:0] pp_tab [8]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic [NB-1:0] jn_tab [8]  = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                   4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [NB-1:0] cur;

    initial begin
        // Reset state
        #12;
        expect_out("reset", 4'b0001, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        i_reset = 1'b0;

        // Rotate-left, step every tick
        i_mode = 2'b00;
        i_div  = 8'd0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1);
            expect_out($sformatf("rol%0d", k), rl_tab[k], 1'b1, (k == 3));
        end

        // Ping-pong from reset
        do_reset();
        i_mode = 2'b10;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1);
            expect_out($sformatf("pp%0d", k), pp_tab[k], 1'b1, (k == 5));
        end

        // Johnson with divide-by-3
        do_reset();
        i_mode = 2'b11;
        i_div  = 8'd2;
        cur    = 4'b0001;
        for (int t = 0; t < 24; t++) begin
            cyc(1'b1);
            if ((t % 3) == 2) begin
                cur = jn_tab[t / 3];
                expect_out($sformatf("jn%0d", t), cur, 1'b1, (t == 23));
            end else begin
                expect_out($sformatf("jn%0d", t), cur, 1'b0, 1'b0);
            end
        end

        // Load beats valid and restarts the divider
        i_mode = 2'b01;
        i_div  = 8'd1;
        cyc(1'b1);
        expect_out("pre_load", 4'b0001, 1'b0, 1'b0);
        i_load    = 1'b1;
        i_pattern = 4'b0100;
        cyc(1'b1);
        expect_out("load", 4'b0100, 1'b0, 1'b0);
        i_load = 1'b0;
        cyc(1'b1);
        expect_out("load_cnt1", 4'b0100, 1'b0, 1'b0);
        cyc(1'b1);
        expect_out("load_step", 4'b0010, 1'b1, 1'b0);

        // All-zero pattern: rotate holds zero, Johnson recovers
        i_mode    = 2'b00;
        i_div     = 8'd0;
        i_load    = 1'b1;
        i_pattern = 4'b0000;
        cyc(1'b0);
        i_load = 1'b0;
        expect_out("zero_load", 4'b0000, 1'b0, 1'b0);
        cyc(1'b1);
        expect_out("zero_rol", 4'b0000, 1'b1, 1'b0);
        i_mode = 2'b11;
        cyc(1'b1);
        expect_out("zero_jn", 4'b0001, 1'b1, 1'b1);
        cyc(1'b0);
        expect_out("hold", 4'b0001, 1'b0, 1'b0);

        // Build o_led=1000, dir=right, div_cnt=5, then reset asynchronously
        do_reset();
        i_mode = 2'b10;
        i_div  = 8'd0;
        for (int k = 0; k < 5; k++) cyc(1'b1);
        expect_out("pp_r", 4'b0010, 1'b1, 1'b0);
        i_mode = 2'b01;
        cyc(1'b1);
        cyc(1'b1);
        expect_out("ror_to_msb", 4'b1000, 1'b1, 1'b0);
        i_div = 8'd7;
        for (int k = 0; k < 5; k++) cyc(1'b1);
        expect_out("cnt5", 4'b1000, 1'b0, 1'b0);
        i_valid = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        expect_out("async_rst", 4'b0001, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        i_mode  = 2'b10;
        i_div   = 8'd2;
        cyc(1'b1);
        cyc(1'b1);
        expect_out("rst_cnt", 4'b0001, 1'b0, 1'b0);
        cyc(1'b1);
        expect_out("rst_step", 4'b0010, 1'b1, 1'b0);
        i_div = 8'd0;
        cyc(1'b1);
        expect_out("rst_left", 4'b0100, 1'b1, 1'b0);

`ifdef SHIFTREG_WRAP_CNT_EN
        do_reset();
        check("wcnt_reset", 32'(o_wrap_cnt), 32'd0);
        i_mode = 2'b00;
        i_div  = 8'd0;
        for (int k = 0; k < 12; k++) cyc(1'b1);
        check("wcnt_12", 32'(o_wrap_cnt), 32'd3);
        i_load    = 1'b1;
        i_pattern = 4'b1000;
        cyc(1'b0);
        i_load = 1'b0;
        check("wcnt_load", 32'(o_wrap_cnt), 32'd0);
        cyc(1'b1);
        check("wcnt_inc", 32'(o_wrap_cnt), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
